// File: rtl/alu_operand_pipe.sv
// Purpose : selects the ALU source/destination operand pair and registers it behind a valid/ready stage.
// Latency : 1 cycle from accept to output when the main register is empty or being popped.
// Backpr. : 2-entry skid (main + skid register); in_ready is a flop and drops only when both are full.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   flush              synchronous discard of all buffered entries (beats acc/pop)
//   in_valid/in_ready  request handshake; alu_in_sel selects the pair from data/pc/offset/sr/dr
//   out_valid/out_ready result handshake; alu_sr/alu_dr/out_sel hold the selected pair and its code
module alu_operand_pipe #(
  parameter int WIDTH    = 16,
  parameter int OFF_W    = 8,
  parameter bit OFF_SEXT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_in_sel,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] pc,
  input  logic [OFF_W-1:0] offset,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] dr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_sr,
  output logic [WIDTH-1:0] alu_dr,
  output logic [2:0]       out_sel
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_n;
  logic             acc, pop;
  logic             load_m_in, load_m_s, load_s;
  logic [WIDTH-1:0] x_ext;
  logic [WIDTH-1:0] sel_sr, sel_dr;
  logic [WIDTH-1:0] s_sr, s_dr;
  logic [2:0]       s_sel;
  logic             in_ready_q, out_valid_q;

  // Offset extension; the full-width case needs no replication at all.
  generate
    if (OFF_W == WIDTH) begin : g_ext_none
      assign x_ext = offset;
    end else begin : g_ext
      logic fill;
      assign fill  = OFF_SEXT ? offset[OFF_W-1] : 1'b0;
      assign x_ext = {{(WIDTH-OFF_W){fill}}, offset};
    end
  endgenerate

  // Selection happens on the input cycle so stored entries never see later input changes.
  always_comb begin
    sel_sr = '0;
    sel_dr = '0;
    case (alu_in_sel)
      3'b000: begin sel_sr = sr;    sel_dr = dr;   end
      3'b001: begin sel_sr = sr;                   end
      3'b010: begin                 sel_dr = dr;   end
      3'b011: begin sel_sr = x_ext; sel_dr = pc;   end
      3'b100: begin                 sel_dr = pc;   end
      3'b101: begin                 sel_dr = data; end
      3'b110: begin sel_sr = x_ext; sel_dr = dr;   end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc       = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;

  always_comb begin
    state_n   = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          state_n   = ONE;
          load_m_in = 1'b1;
        end
        ONE: begin
          if (acc && !pop) begin
            state_n = FULL;
            load_s  = 1'b1;
          end else if (acc && pop) begin
            load_m_in = 1'b1;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        FULL: if (pop) begin
          // in_ready is low here, so no new request can arrive alongside the pop.
          state_n  = ONE;
          load_m_s = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_sr      <= '0;
      alu_dr      <= '0;
      out_sel     <= 3'b000;
      s_sr        <= '0;
      s_dr        <= '0;
      s_sel       <= 3'b000;
    end else begin
      state       <= state_n;
      // Handshake flags are registered copies of the next-state decode.
      in_ready_q  <= (state_n != FULL);
      out_valid_q <= (state_n != EMPTY);
      if (load_m_in) begin
        alu_sr  <= sel_sr;
        alu_dr  <= sel_dr;
        out_sel <= alu_in_sel;
      end else if (load_m_s) begin
        alu_sr  <= s_sr;
        alu_dr  <= s_dr;
        out_sel <= s_sel;
      end
      if (load_s) begin
        s_sr  <= sel_sr;
        s_dr  <= sel_dr;
        s_sel <= alu_in_sel;
      end
    end
  end

endmodule
